dino_game_core: RTL
===================

# dino_game_core

Parametrised game-state core for the 128x64 OLED dino game, replacing the single-obstacle, multi-clock pattern logic. It runs entirely on one clock with qualified strobes. It owns:

- the START/PLAY/PAUSE/OVER state machine,
- N independent obstacle slots with LFSR-randomised spawning,
- speed scaling,
- a saturating BCD score and a high score.

It renders the ground and obstacle layer per pixel for the screen driver; sprite and splash-screen overlays sit downstream.

## Interface
Parameters:
- N_OBS, 3: number of obstacle slots (1–8).
- SCREEN_W, 128: display width in columns.
- OBS_W, 8: obstacle width in columns.
- CAT_X, 36: left column of cat hitbox.
- CAT_W, 16: cat hitbox width.
- MIN_GAP, 20: minimum frames between spawns.
- GAP_MASK, 8'h3F: LFSR bits added to MIN_GAP.
- SPEED_STEP, 250: score ticks per speed increment.
- MAX_SPEED, 4: speed saturation value.

Ports:
- CLK_27MHZ  in  1  system clock; all flops on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- frame_strobe  in  1  one-cycle pulse per display frame.
- score_strobe  in  1  one-cycle pulse per score tick.
- button  in  1  raw active-low button, asynchronous to clock.
- jump  in  1  1 = cat airborne.
- pixel_index  in  10  byte address 0–1023 (row = idx[9:7], col = idx[6:0]).
- pixel_byte  out  8  registered ground/obstacle pattern for pixel_index.
- state  out  2  00 START, 01 PLAY, 10 OVER, 11 PAUSE.
- game_on  out  1  state == PLAY.
- collision  out  1  one-cycle pulse on PLAY→OVER.
- score_bcd  out  16  four BCD digits, thousands in [15:12].
- hiscore_bcd  out  16  best score since reset.
- speed  out  3  current speed, 1..MAX_SPEED.
- obs_active  out  N_OBS  per-slot active flags.

## Operation

**Reset values.**
- state = START; score_bcd = 0; hiscore_bcd = 0; speed = 1.
- All slots inactive with pos = 0; gap counter = MIN_GAP; LFSR = 16'hACE1.
- pixel_byte = 0; collision = 0.

**Button input.**
- `button` passes through a 2-flop synchroniser, then a falling-edge detector, giving `press` (one cycle).
- The synchroniser resets to 1.

**State machine.**
- START + press → PLAY. On this transition: score = 0; speed = 1; all slots inactive; gap = MIN_GAP; step counter = 0.
- PLAY + press → PAUSE.
- PLAY + hit at frame_strobe → OVER. Collision takes priority over a same-cycle press.
- PAUSE + press → PLAY. PAUSE freezes obstacles, score and gap.
- OVER + press → START.

**Obstacles.**
- Slot position `pos` is 8 bits. A slot occupies columns [pos−OBS_W, pos−1], clipped to the screen.
- On frame_strobe in PLAY, each active slot updates:
  - if pos ≤ speed: the slot deactivates;
  - otherwise: pos −= speed.
- Spawning, also on frame_strobe in PLAY:
  - If gap > 0, gap decrements.
  - If gap == 0 and any slot is free, the lowest-index free slot activates with pos = SCREEN_W+OBS_W, and gap reloads to MIN_GAP + (lfsr[7:0] & GAP_MASK).
  - If gap == 0 and no slot is free, gap holds at 0 and the spawn retries on the next frame.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. It advances on every frame_strobe regardless of state.

**Collision.**
- `hit` = OR over active slots of: (pos−OBS_W < CAT_X+CAT_W) AND (pos > CAT_X) AND !jump.
- Evaluation uses pre-update positions on frame_strobe in PLAY.

**Score and speed.**
- On score_strobe in PLAY, score increments by 1 in BCD with per-digit carry, saturating at 9999.
- A step counter counts score ticks. When it reaches SPEED_STEP−1, it clears and speed increments, saturating at MAX_SPEED.
- On the PLAY→OVER transition, if score > hiscore (compared as BCD), hiscore = score.

**Rendering.** Applies only in PLAY or PAUSE; in any other state pixel_byte = 8'h00.
- row 6 → 8'hF0;
- otherwise row 5 with col inside any active slot → 8'hFF;
- otherwise 8'h00.

## Timing
- pixel_byte: 1 cycle latency from pixel_index; fully pipelined, one pixel per clock.
- press: 3 cycles after the button falling edge (2 synchroniser stages + edge register). State changes on the following clock edge.
- Obstacle, gap, speed and state updates complete on the same edge as frame_strobe / score_strobe. New values are visible the next cycle.
- collision: asserted for exactly the one cycle after the edge at which state becomes OVER.
- Simultaneous frame_strobe and score_strobe: both are applied in the same cycle. The score_strobe increment still occurs even if the frame_strobe causes the move to OVER; hiscore compares against the pre-increment score.
- RST_N asserted mid-game returns every output to its reset value asynchronously. The first press after release is required to start a game.

## Test plan
- Reset, then button low for 10 cycles → state 00→01 four cycles after the edge; score_bcd = 0; obs_active = 0.
- PLAY with jump = 1 throughout, 21 frame_strobes → slot 0 active at pos = 136 after strobe 21; next strobe pos = 135; a second spawn goes to slot 1 after the reloaded gap.
- 1000 score_strobes in PLAY → score_bcd = 16'h1000; speed = 5 clamped to 4 (MAX_SPEED); check digit carry 0999→1000.
- jump = 0 with slot 0 at pos = 40 on frame_strobe → state = 10, collision high for one cycle, hiscore_bcd = score_bcd; press → state 00.
- PAUSE: press in PLAY, 50 frame_strobes → obstacle positions and score unchanged; press → PLAY resumes from the same positions.
- pixel_index = 6*128+3 → pixel_byte = F0 one cycle later. An index on row 5 inside an active slot → FF. The same indices in START → 00.

Source files
------------

// File: rtl/dino_game_core_if.sv
// Bundles the per-frame strobes, button/jump inputs, pixel lookup and game status outputs
// of dino_game_core.
//   master : drives strobes, button, jump and pixel_index; observes everything else
//   slave  : the game core itself
interface dino_game_core_if #(
    parameter int N_OBS = 3
);
    logic             frame_strobe;  // one-cycle pulse per display frame
    logic             score_strobe;  // one-cycle pulse per score tick
    logic             button;        // raw active-low button, asynchronous
    logic             jump;          // 1 = cat airborne
    logic [9:0]       pixel_index;   // row = [9:7], col = [6:0]
    logic [7:0]       pixel_byte;    // registered ground/obstacle pattern
    logic [1:0]       state;         // 00 START, 01 PLAY, 10 OVER, 11 PAUSE
    logic             game_on;       // state == PLAY
    logic             collision;     // one-cycle pulse after PLAY -> OVER
    logic [15:0]      score_bcd;     // four BCD digits
    logic [15:0]      hiscore_bcd;   // best score since reset
    logic [2:0]       speed;         // 1..MAX_SPEED
    logic [N_OBS-1:0] obs_active;    // per-slot active flags

    modport master (
        output frame_strobe, score_strobe, button, jump, pixel_index,
        input  pixel_byte, state, game_on, collision, score_bcd, hiscore_bcd, speed, obs_active
    );

    modport slave (
        input  frame_strobe, score_strobe, button, jump, pixel_index,
        output pixel_byte, state, game_on, collision, score_bcd, hiscore_bcd, speed, obs_active
    );
endinterface

// File: rtl/dino_game_core.sv
// Game-state core for the 128x64 OLED dino game. Single clock, strobe-qualified updates.
// Owns the START/PLAY/PAUSE/OVER state machine, N_OBS obstacle slots with LFSR-randomised
// spawning, speed scaling, saturating BCD score and high score, and renders the ground and
// obstacle layer one byte per clock.
// Ports:
//   CLK_27MHZ : system clock, rising edge
//   RST_N     : asynchronous active-low reset
//   bus       : dino_game_core_if.slave (strobes, button, jump, pixel lookup, status outputs)
module dino_game_core #(
    parameter int         N_OBS      = 3,
    parameter int         SCREEN_W   = 128,
    parameter int         OBS_W      = 8,
    parameter int         CAT_X      = 36,
    parameter int         CAT_W      = 16,
    parameter int         MIN_GAP    = 20,
    parameter logic [7:0] GAP_MASK   = 8'h3F,
    parameter int         SPEED_STEP = 250,
    parameter int         MAX_SPEED  = 4
) (
    input logic               CLK_27MHZ,
    input logic               RST_N,
    dino_game_core_if.slave   bus
);

    typedef enum logic [1:0] {
        StStart = 2'b00,
        StPlay  = 2'b01,
        StOver  = 2'b10,
        StPause = 2'b11
    } state_t;

    state_t           state_q;
    logic             btn_s1_q, btn_s2_q, btn_s3_q, press_q;
    logic [15:0]      lfsr_q;
    logic [N_OBS-1:0] active_q;
    logic [7:0]       pos_q [N_OBS];
    logic [7:0]       gap_q;
    logic [15:0]      score_q, hiscore_q;
    logic [2:0]       speed_q;
    logic [15:0]      step_q;
    logic             collision_q;
    logic [7:0]       pixel_byte_q;

    logic             hit;
    logic             any_free;
    logic [N_OBS-1:0] spawn_sel;
    logic [15:0]      score_inc;
    logic             carry;
    logic [7:0]       gap_reload;
    logic             lfsr_fb;
    logic [2:0]       pix_row;
    logic [6:0]       pix_col;
    logic             in_obs;
    logic [7:0]       pixel_d;

    // Hit test, lowest free slot and saturating BCD increment, all on current state.
    always_comb begin
        hit       = 1'b0;
        any_free  = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < N_OBS; i++) begin
            if (active_q[i] && (int'(pos_q[i]) - OBS_W < CAT_X + CAT_W) &&
                (int'(pos_q[i]) > CAT_X) && !bus.jump) begin
                hit = 1'b1;
            end
            if (!active_q[i] && !any_free) begin
                spawn_sel[i] = 1'b1;
                any_free     = 1'b1;
            end
        end

        score_inc = score_q;
        carry     = 1'b1;
        if (score_q != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (score_q[4*d +: 4] == 4'd9) begin
                        score_inc[4*d +: 4] = 4'd0;
                    end else begin
                        score_inc[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
                        carry               = 1'b0;
                    end
                end
            end
        end

        gap_reload = 8'(MIN_GAP) + (lfsr_q[7:0] & GAP_MASK);
        // Right-shifting Fibonacci form of taps 16/14/13/11.
        lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    end

    // Pixel renderer: ground on row 6, obstacles on row 5, blank outside PLAY/PAUSE.
    always_comb begin
        pix_row = bus.pixel_index[9:7];
        pix_col = bus.pixel_index[6:0];
        in_obs  = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (active_q[i] && (int'(pix_col) < int'(pos_q[i])) &&
                (int'(pix_col) >= int'(pos_q[i]) - OBS_W)) begin
                in_obs = 1'b1;
            end
        end
        pixel_d = 8'h00;
        if (state_q == StPlay || state_q == StPause) begin
            if (pix_row == 3'd6) begin
                pixel_d = 8'hF0;
            end else if (pix_row == 3'd5 && in_obs) begin
                pixel_d = 8'hFF;
            end
        end
    end

    // Button synchroniser and registered falling-edge detector.
    always_ff @(posedge CLK_27MHZ or negedge RST_N) begin
        if (!RST_N) begin
            btn_s1_q <= 1'b1;
            btn_s2_q <= 1'b1;
            btn_s3_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            btn_s1_q <= bus.button;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            press_q  <= btn_s3_q & ~btn_s2_q;
        end
    end

    // LFSR runs on every frame regardless of game state.
    always_ff @(posedge CLK_27MHZ or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= 16'hACE1;
        end else if (bus.frame_strobe) begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge CLK_27MHZ or negedge RST_N) begin
        if (!RST_N) begin
            pixel_byte_q <= 8'h00;
        end else begin
            pixel_byte_q <= pixel_d;
        end
    end

    // Game state machine with obstacle, gap, score and speed updates.
    always_ff @(posedge CLK_27MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StStart;
            active_q    <= '0;
            for (int i = 0; i < N_OBS; i++) begin
                pos_q[i] <= 8'd0;
            end
            gap_q       <= 8'(MIN_GAP);
            score_q     <= 16'h0000;
            hiscore_q   <= 16'h0000;
            speed_q     <= 3'd1;
            step_q      <= 16'd0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= 1'b0;
            unique case (state_q)
                StStart: begin
                    if (press_q) begin
                        state_q  <= StPlay;
                        score_q  <= 16'h0000;
                        speed_q  <= 3'd1;
                        active_q <= '0;
                        gap_q    <= 8'(MIN_GAP);
                        step_q   <= 16'd0;
                    end
                end
                StPlay: begin
                    // A hit freezes the obstacle field as it was when the cat was struck.
                    if (bus.frame_strobe && hit) begin
                        state_q     <= StOver;
                        collision_q <= 1'b1;
                        if (score_q > hiscore_q) begin
                            hiscore_q <= score_q;
                        end
                    end else begin
                        if (press_q) begin
                            state_q <= StPause;
                        end
                        if (bus.frame_strobe) begin
                            for (int i = 0; i < N_OBS; i++) begin
                                if (active_q[i]) begin
                                    if (pos_q[i] <= {5'd0, speed_q}) begin
                                        active_q[i] <= 1'b0;
                                    end else begin
                                        pos_q[i] <= pos_q[i] - {5'd0, speed_q};
                                    end
                                end else if (gap_q == 8'd0 && spawn_sel[i]) begin
                                    active_q[i] <= 1'b1;
                                    pos_q[i]    <= 8'(SCREEN_W + OBS_W);
                                end
                            end
                            // With no free slot the gap holds at zero and retries next frame.
                            if (gap_q != 8'd0) begin
                                gap_q <= gap_q - 8'd1;
                            end else if (any_free) begin
                                gap_q <= gap_reload;
                            end
                        end
                    end
                    // Score tick still lands on the frame that ends the game.
                    if (bus.score_strobe) begin
                        score_q <= score_inc;
                        if (step_q == 16'(SPEED_STEP - 1)) begin
                            step_q <= 16'd0;
                            if (speed_q < 3'(MAX_SPEED)) begin
                                speed_q <= speed_q + 3'd1;
                            end
                        end else begin
                            step_q <= step_q + 16'd1;
                        end
                    end
                end
                StPause: begin
                    if (press_q) begin
                        state_q <= StPlay;
                    end
                end
                StOver: begin
                    if (press_q) begin
                        state_q <= StStart;
                    end
                end
            endcase
        end
    end

    assign bus.pixel_byte  = pixel_byte_q;
    assign bus.state       = state_q;
    assign bus.game_on     = (state_q == StPlay);
    assign bus.collision   = collision_q;
    assign bus.score_bcd   = score_q;
    assign bus.hiscore_bcd = hiscore_q;
    assign bus.speed       = speed_q;
    assign bus.obs_active  = active_q;

endmodule
